// File: rtl/uart6551_baudgen.sv
// uart6551_baudgen: 16x/1x baud enables from the 6551 rate table, an override increment, or an external 16x clock.
// Latency: synthesised first pulse at edge ceil(2^ACC_W/inc) after restart; external edge reaches baud16x_ce 3 clk edges after capture.
// Backpressure: none; free-running enables, and any source change or clear restarts cleanly with no glitch pulse.
module uart6551_baudgen #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned ACC_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       baud_sel,
  input  logic             ext_clk,
  input  logic             inc_ovr_en,
  input  logic [ACC_W-1:0] inc_ovr,
  input  logic             clear,
  output logic             baud16x_ce,
  output logic             baud1x_ce,
  output logic             baud_clk
);

  // Rates are held in hundredths of a baud so the two fractional entries stay exact.
  function automatic logic [ACC_W-1:0] calc_inc(input int k);
    logic [127:0] rate_c;
    logic [127:0] num;
    logic [127:0] den;
    case (k)
      1:       rate_c = 128'd5000;
      2:       rate_c = 128'd7500;
      3:       rate_c = 128'd10992;
      4:       rate_c = 128'd13458;
      5:       rate_c = 128'd15000;
      6:       rate_c = 128'd30000;
      7:       rate_c = 128'd60000;
      8:       rate_c = 128'd120000;
      9:       rate_c = 128'd180000;
      10:      rate_c = 128'd240000;
      11:      rate_c = 128'd360000;
      12:      rate_c = 128'd480000;
      13:      rate_c = 128'd720000;
      14:      rate_c = 128'd960000;
      15:      rate_c = 128'd1920000;
      default: rate_c = 128'd0;
    endcase
    num = (rate_c * 128'd16) << ACC_W;
    den = 128'd100 * 128'(CLK_FREQ);
    calc_inc = ACC_W'((num + (den >> 1)) / den);
  endfunction

  // Constant increment ROM; entry 0 is unused (external clock select).
  logic [ACC_W-1:0] inc_rom [16];
  for (genvar k = 0; k < 16; k++) begin : g_rom
    localparam logic [ACC_W-1:0] INC_K = calc_inc(k);
    assign inc_rom[k] = INC_K;
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce16_q, ce16_d;
  logic             ce1_q, ce1_d;
  logic             bclk_q, bclk_d;
  logic [3:0]       div16_q, div16_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic [3:0]       sel_prev_q, sel_prev_d;
  logic             ovr_en_prev_q, ovr_en_prev_d;
  logic [ACC_W-1:0] ovr_prev_q, ovr_prev_d;
  logic             armed_q, armed_d;

  logic [ACC_W-1:0] inc_eff;
  logic [ACC_W:0]   sum;
  logic             ext_mode;
  logic             restart;
  logic             pulse;

  // Source selection, restart detection and next-state for accumulator, prescaler and outputs.
  always_comb begin
    inc_eff  = inc_ovr_en ? inc_ovr : inc_rom[baud_sel];
    ext_mode = !inc_ovr_en && (baud_sel == 4'd0);
    // armed_q masks the first cycle after reset so the reset value of the
    // previous-select registers never looks like a source change.
    restart  = clear || (armed_q && ((baud_sel != sel_prev_q) ||
                                     (inc_ovr_en != ovr_en_prev_q) ||
                                     (inc_ovr != ovr_prev_q)));
    sum      = {1'b0, acc_q} + {1'b0, inc_eff};
    pulse    = ext_mode ? (sync2_q & ~sync3_q) : sum[ACC_W];

    sync1_d       = ext_clk;
    sync2_d       = sync1_q;
    sync3_d       = sync2_q;
    sel_prev_d    = baud_sel;
    ovr_en_prev_d = inc_ovr_en;
    ovr_prev_d    = inc_ovr;
    armed_d       = 1'b1;

    acc_d   = '0;
    ce16_d  = 1'b0;
    ce1_d   = 1'b0;
    div16_d = 4'd0;
    bclk_d  = 1'b0;
    if (!restart) begin
      acc_d   = ext_mode ? '0 : sum[ACC_W-1:0];
      ce16_d  = pulse;
      ce1_d   = pulse && (div16_q == 4'hF);
      div16_d = div16_q + {3'b000, pulse};
      bclk_d  = bclk_q ^ pulse;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      ce16_q        <= 1'b0;
      ce1_q         <= 1'b0;
      bclk_q        <= 1'b0;
      div16_q       <= 4'd0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      sel_prev_q    <= 4'd0;
      ovr_en_prev_q <= 1'b0;
      ovr_prev_q    <= '0;
      armed_q       <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      ce16_q        <= ce16_d;
      ce1_q         <= ce1_d;
      bclk_q        <= bclk_d;
      div16_q       <= div16_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      sel_prev_q    <= sel_prev_d;
      ovr_en_prev_q <= ovr_en_prev_d;
      ovr_prev_q    <= ovr_prev_d;
      armed_q       <= armed_d;
    end
  end

  assign baud16x_ce = ce16_q;
  assign baud1x_ce  = ce1_q;
  assign baud_clk   = bclk_q;

endmodule
